// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/compare ops plus iterative multiply/divide.
// Define ULA_SEQ_MULDIV_EN to include the WIDTH-cycle shift-add multiplier and restoring divider.
module ula_seq #(
  parameter int WIDTH = 32,
  parameter int SMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [SMT_W-1:0] smt,
  input  logic [4:0]       aluop,
  output logic [WIDTH-1:0] r1,
  output logic             UF,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_AND = 5'b00011;
  localparam logic [4:0] OP_OR  = 5'b00100;
  localparam logic [4:0] OP_NOT = 5'b00101;
  localparam logic [4:0] OP_XOR = 5'b00110;
  localparam logic [4:0] OP_SLL = 5'b00111;
  localparam logic [4:0] OP_SRL = 5'b01000;
  localparam logic [4:0] OP_LT  = 5'b01001;
  localparam logic [4:0] OP_GT  = 5'b01010;
  localparam logic [4:0] OP_EQ  = 5'b01011;
  localparam logic [4:0] OP_NE  = 5'b01100;
  localparam logic [4:0] OP_LE  = 5'b01101;
  localparam logic [4:0] OP_GE  = 5'b01110;
  localparam logic [4:0] OP_LUP = 5'b01111;

`ifdef ULA_SEQ_MULDIV_EN
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b10001;
  localparam logic [SMT_W-1:0] CNT_LAST = SMT_W'(WIDTH - 1);
  localparam logic [SMT_W-1:0] CNT_ONE  = 1;

  typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, DONE} state_t;
`endif

  state_t state, nstate;

  logic [WIDTH-1:0] a_q, b_q;
  logic [SMT_W-1:0] s_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] exec_r;
  logic             exec_uf;

`ifdef ULA_SEQ_MULDIV_EN
  logic [SMT_W-1:0]   cnt;
  logic               last;
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH:0]     madd;
  logic [WIDTH-1:0]   quo, quo_nx, rem, rem_nx;
  logic [WIDTH:0]     shifted, diff;

  assign last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // busy covers DONE too, so a start coinciding with the done pulse is ignored
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ULA_SEQ_MULDIV_EN
          if (aluop == OP_MUL)      nstate = MUL;
          else if (aluop == OP_DIV) nstate = DIV;
          else                      nstate = EXEC;
`else
          nstate = EXEC;
`endif
        end
      end
      EXEC: begin
        busy   = 1'b1;
        nstate = DONE;
      end
`ifdef ULA_SEQ_MULDIV_EN
      MUL, DIV: begin
        busy = 1'b1;
        if (last) nstate = DONE;
      end
`endif
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    exec_r  = '0;
    exec_uf = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_r  = a_q + b_q;
        exec_uf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (exec_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_r  = a_q - b_q;
        exec_uf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (exec_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: exec_r = a_q & b_q;
      OP_OR:  exec_r = a_q | b_q;
      OP_NOT: exec_r = ~a_q;
      OP_XOR: exec_r = a_q ^ b_q;
      OP_SLL: exec_r = a_q << s_q;
      OP_SRL: exec_r = a_q >> s_q;
      OP_LT:  exec_uf = (a_q <  b_q);
      OP_GT:  exec_uf = (a_q >  b_q);
      OP_EQ:  exec_uf = (a_q == b_q);
      OP_NE:  exec_uf = (a_q != b_q);
      OP_LE:  exec_uf = (a_q <= b_q);
      OP_GE:  exec_uf = (a_q >= b_q);
      OP_LUP: exec_r = b_q << (WIDTH / 2);
      default: exec_r = b_q;
    endcase
  end

`ifdef ULA_SEQ_MULDIV_EN
  // prod holds {partial sum, remaining multiplier bits}; quo shifts dividend bits out as quotient bits enter
  always_comb begin
    madd    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : '0);
    prod_nx = {madd, prod[WIDTH-1:1]};
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (!diff[WIDTH]) begin
      rem_nx = diff[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      s_q  <= '0;
      op_q <= '0;
      r1   <= '0;
      UF   <= 1'b0;
`ifdef ULA_SEQ_MULDIV_EN
      cnt  <= '0;
      prod <= '0;
      quo  <= '0;
      rem  <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        a_q  <= op1;
        b_q  <= op2;
        s_q  <= smt;
        op_q <= aluop;
`ifdef ULA_SEQ_MULDIV_EN
        cnt  <= '0;
        prod <= {{WIDTH{1'b0}}, op2};
        quo  <= op1;
        rem  <= '0;
`endif
      end
      if (state == EXEC) begin
        r1 <= exec_r;
        UF <= exec_uf;
      end
`ifdef ULA_SEQ_MULDIV_EN
      if (state == MUL) begin
        prod <= prod_nx;
        cnt  <= cnt + CNT_ONE;
        if (last) begin
          r1 <= prod_nx[WIDTH-1:0];
          UF <= |prod_nx[2*WIDTH-1:WIDTH];
        end
      end
      if (state == DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + CNT_ONE;
        if (last) begin
          r1 <= (b_q == '0) ? '1 : quo_nx;
          UF <= (b_q == '0);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed self-checking bench for ula_seq; expectations follow ULA_SEQ_MULDIV_EN when it is defined.
module tb_ula_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op1, op2;
  logic [4:0]  smt;
  logic [4:0]  aluop;
  logic [31:0] r1;
  logic        UF;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;
  int lat;
  int pulses;

  ula_seq #(.WIDTH(32), .SMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op1(op1), .op2(op2),
    .smt(smt), .aluop(aluop), .r1(r1), .UF(UF), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Waits one negedge so the FSM has left DONE, then holds start for one rising edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] s);
    @(negedge clk);
    aluop = op; op1 = a; op2 = b; smt = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int elapsed, output int cycles);
    cycles = 999;
    for (int i = elapsed + 1; i <= 80; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s, input logic [31:0] er,
                       input logic eu, input int elat);
    int l;
    applyStimulus(op, a, b, s);
    waitDone(0, l);
    checkOutput({tag, "_r1"}, r1, er);
    checkOutput({tag, "_uf"}, {31'b0, UF}, {31'b0, eu});
    checkOutput({tag, "_lat"}, l, elat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; smt = '0; aluop = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_r1",   r1, 32'h0);
    checkOutput("rst_uf",   {31'b0, UF}, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", {31'b0, busy}, 32'h0);

    runOp("add_ovf", 5'b00001, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b1, 2);
    @(negedge clk);
    checkOutput("done_pulse", {31'b0, done}, 32'h0);
    checkOutput("hold_r1", r1, 32'h80000000);
    checkOutput("hold_uf", {31'b0, UF}, 32'h1);
    checkOutput("post_busy", {31'b0, busy}, 32'h0);

    runOp("sub_ovf", 5'b00010, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b1, 2);
    runOp("sub",     5'b00010, 32'h5, 32'h3, 5'd0, 32'h2, 1'b0, 2);
    runOp("add",     5'b00001, 32'h12345678, 32'h11111111, 5'd0, 32'h23456789, 1'b0, 2);
    runOp("and",     5'b00011, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 1'b0, 2);
    runOp("or",      5'b00100, 32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 1'b0, 2);
    runOp("not",     5'b00101, 32'h0F0F0000, 32'h0, 5'd0, 32'hF0F0FFFF, 1'b0, 2);
    runOp("xor",     5'b00110, 32'hF0, 32'hFF, 5'd0, 32'h0F, 1'b0, 2);
    runOp("sll",     5'b00111, 32'h1, 32'h0, 5'd31, 32'h80000000, 1'b0, 2);
    runOp("srl",     5'b01000, 32'h80000000, 32'h0, 5'd4, 32'h08000000, 1'b0, 2);
    runOp("lt",      5'b01001, 32'h3, 32'h5, 5'd0, 32'h0, 1'b1, 2);
    runOp("gt",      5'b01010, 32'h3, 32'h5, 5'd0, 32'h0, 1'b0, 2);
    runOp("eq",      5'b01011, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 2);
    runOp("ne",      5'b01100, 32'h5, 32'h5, 5'd0, 32'h0, 1'b0, 2);
    runOp("le",      5'b01101, 32'h5, 32'h3, 5'd0, 32'h0, 1'b0, 2);
    runOp("ge_uns",  5'b01110, 32'h80000000, 32'h1, 5'd0, 32'h0, 1'b1, 2);
    runOp("ldup",    5'b01111, 32'hFFFFFFFF, 32'h00001234, 5'd0, 32'h12340000, 1'b0, 2);
    runOp("undef",   5'b11111, 32'h1, 32'h0000ABCD, 5'd0, 32'h0000ABCD, 1'b0, 2);

`ifdef ULA_SEQ_MULDIV_EN
    // Second start during the multiply must not disturb the latched operands.
    applyStimulus(5'b10000, 32'h00010000, 32'h00010000, 5'd0);
    repeat (4) @(negedge clk);
    checkOutput("mul_busy", {31'b0, busy}, 32'h1);
    aluop = 5'b00001; op1 = 32'h3; op2 = 32'h3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(4, lat);
    checkOutput("mul_big_r1",  r1, 32'h0);
    checkOutput("mul_big_uf",  {31'b0, UF}, 32'h1);
    checkOutput("mul_big_lat", lat, 33);
    runOp("mul_small", 5'b10000, 32'h3, 32'h5, 5'd0, 32'hF, 1'b0, 33);
    runOp("mul_mid",   5'b10000, 32'h0000FFFF, 32'h0000FFFF, 5'd0, 32'hFFFE0001, 1'b0, 33);
    runOp("div",       5'b10001, 32'h100, 32'h7, 5'd0, 32'h24, 1'b0, 33);
    runOp("div_zero",  5'b10001, 32'h100, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b1, 33);

    applyStimulus(5'b10001, 32'h100, 32'h7, 5'd0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    checkOutput("abort_done", {31'b0, done}, 32'h0);
    checkOutput("abort_r1",   r1, 32'h0);
    checkOutput("abort_uf",   {31'b0, UF}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_nodone", pulses, 0);
    runOp("xor_after_rst", 5'b00110, 32'hF0, 32'hFF, 5'd0, 32'h0F, 1'b0, 2);
`else
    runOp("mul_off", 5'b10000, 32'h5, 32'h1234, 5'd0, 32'h1234, 1'b0, 2);
    runOp("div_off", 5'b10001, 32'h100, 32'h5678, 5'd0, 32'h5678, 1'b0, 2);

    // A start during EXEC is ignored; the add uses the first operand pair.
    applyStimulus(5'b00001, 32'h10, 32'h20, 5'd0);
    aluop = 5'b00110; op1 = 32'hFF; op2 = 32'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(1, lat);
    checkOutput("ignore_r1",  r1, 32'h30);
    checkOutput("ignore_lat", lat, 2);

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_idle_r1", r1, 32'h0);
    checkOutput("rst_idle_uf", {31'b0, UF}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    runOp("xor_after_rst", 5'b00110, 32'hF0, 32'hFF, 5'd0, 32'h0F, 1'b0, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; legal values are even and at least 8.
REQ-002 Parameter SMT_W, default 5, shift-amount width; shall equal clog2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request; accepted only in a cycle where busy=0.
REQ-006 op1, op2  input  WIDTH  operands, sampled on acceptance.
REQ-007 smt  input  SMT_W  shift amount, sampled on acceptance.
REQ-008 aluop  input  5  operation code, sampled on acceptance.
REQ-009 r1  output  WIDTH  registered result.
REQ-010 UF  output  1  registered flag: overflow, compare outcome or divide-by-zero.
REQ-011 busy  output  1  high from the cycle after acceptance until the cycle done is asserted.
REQ-012 done  output  1  one-cycle pulse; r1 and UF are valid in that cycle.

Function
REQ-013 FSM states: IDLE, EXEC, MUL, DIV, DONE; reset state is IDLE.
REQ-014 Transition rule: IDLE + start goes to MUL for 10000, to DIV for 10001, otherwise to EXEC.
REQ-015 EXEC goes to DONE after 1 cycle, so single-cycle ops have done 2 cycles after the accept edge.
REQ-016 MUL and DIV iterate exactly WIDTH cycles, then go to DONE.
REQ-017 DONE asserts done for one cycle and returns to IDLE; start in DONE is ignored.
REQ-018 Any start while busy=1 is ignored; latched operands remain unchanged.
REQ-019 r1 and UF hold their values from the last DONE until the next DONE.
REQ-020 Add (00001): r1=op1+op2 mod 2^WIDTH; UF=signed overflow (operand signs equal, result sign differs).
REQ-021 Sub (00010): r1=op1-op2 mod 2^WIDTH; UF=signed overflow (operand signs differ, result sign differs from op1).
REQ-022 Logic ops, UF=0: AND 00011, OR 00100, NOT 00101 (~op1), XOR 00110, SLL 00111 (op1<<smt), SRL 01000 (logical op1>>smt).
REQ-023 Unsigned compares, r1=0, UF=result: 01001 <, 01010 >, 01011 ==, 01100 !=, 01101 <=, 01110 >=.
REQ-024 LoadUp (01111): r1=op2<<(WIDTH/2); UF=0.
REQ-025 Undefined aluop codes: r1=op2, UF=0, single-cycle path.
REQ-026 Mult (10000): shift-add over WIDTH cycles; r1=low WIDTH bits of the unsigned product; UF=1 iff the high WIDTH bits are nonzero.
REQ-027 Div (10001): restoring division over WIDTH cycles; r1=unsigned quotient; UF=0.
REQ-028 Div with op2=0: r1=all ones, UF=1; the full WIDTH-cycle latency is kept.

Reset
REQ-029 rst=1 forces IDLE immediately, independent of clk.
REQ-030 rst=1 clears r1=0, UF=0, busy=0, done=0 and all internal iteration registers.
REQ-031 Reset mid-MUL/DIV aborts the operation with no done pulse; the first start after rst falls is accepted normally.

Configuration
REQ-032 Macro ULA_SEQ_MULDIV_EN defined: MUL/DIV states and datapath are present as in REQ-026..028.
REQ-033 Macro ULA_SEQ_MULDIV_EN undefined: no MUL/DIV logic; 10000/10001 behave as undefined codes per REQ-025.

Verification
REQ-034 Add: op1=7FFFFFFF, op2=1 -> r1=80000000, UF=1, done 2 cycles after accept.
REQ-035 Sub: op1=80000000, op2=1 -> r1=7FFFFFFF, UF=1; op1=5, op2=3 -> r1=2, UF=0.
REQ-036 Mult (macro on): op1=10000, op2=10000 -> r1=0, UF=1, done at accept+WIDTH+1; second start while busy is ignored.
REQ-037 Div (macro on): op1=100, op2=7 -> r1=24 (hex quotient), UF=0; op2=0 -> r1=FFFFFFFF, UF=1.
REQ-038 rst asserted at cycle 10 of DIV -> no done pulse, outputs 0; next start for XOR of F0 and FF -> r1=0F.
REQ-039 Macro off, aluop=10000, op2=1234 -> r1=1234, UF=0, done at accept+2.
